dram_read_arbiter: RTL
======================

// Module: dram_read_arbiter
// PURPOSE
// - Shares the single DRAM read port between two requesters (req0: image data prefetch, req1: auxiliary/camera reader).
// - Captures each requester's one-cycle read pulse, grants round-robin, keeps one transaction in flight, routes read beats to the owner.
// - Sits between the image sender's dram_read_* outputs and the DRAM controller read channel, all in the clk_pixel domain.
// PARAMETERS
// - DRAM_ADDR_WIDTH  39   read address width
// - DRAM_DATA_WIDTH  512  read data width
// - TIMEOUT_CYCLES   4096 watchdog limit in clk_pixel cycles (used only with DRAM_ARB_TIMEOUT_EN)
// PORTS
// - clk_pixel             in   1    single clock; all logic on posedge
// - dram_arbiter_reset    in   1    synchronous, active-high reset
// - reqN_read_addr        in   DAW  N=0,1; sampled when reqN_read_en=1
// - reqN_read_len         in   8    beats-1, sampled with addr
// - reqN_read_en          in   1    one-cycle request pulse
// - reqN_read_busy        out  1    pending or owned-in-flight; requester must not pulse en while 1
// - reqN_read_data_valid  out  1    beat valid for requester N
// - arb_read_data         out  DDW  dram_read_data passed through, shared by both requesters
// - dram_read_addr        out  DAW  to DRAM controller
// - dram_read_len         out  8    to DRAM controller
// - dram_read_en          out  1    one-cycle issue pulse
// - dram_read_data        in   DDW  from DRAM controller
// - dram_read_data_valid  in   1    beat strobe
// - dram_read_busy        in   1    controller cannot accept a new request
// - arb_error             out  2    sticky flags: [0] request overflow, [1] stray beat or timeout
// BEHAVIOUR
// - Reset: all outputs 0. pending0/1=0, state=IDLE, last_grant=1 so req0 wins the first tie. Reset mid-transaction drops it; later beats count as stray.
// - Capture: reqN_read_en=1 and pendingN=0 -> latch addr/len, pendingN<=1 on the next edge.
// - Overflow: reqN_read_en=1 while pendingN=1 or N owns the in-flight read -> request ignored, arb_error[0]<=1.
// - reqN_read_busy = pendingN | (state!=IDLE & owner==N). Combinational from registers.
// - FSM states:
//   - IDLE: if any pending & ~dram_read_busy -> grant, go to ISSUE. Both pending -> grant !last_grant.
//     On grant: owner<=N, last_grant<=N, pendingN<=0, beat_cnt<=lenN.
//   - ISSUE: dram_read_en=1 for exactly this cycle; addr/len = latched values of owner; -> DATA.
//   - DATA: each dram_read_data_valid -> beat_cnt-1. Valid with beat_cnt==0 -> IDLE.
//     This is the last beat (len+1 beats total).
// - Latency: en captured at cycle t -> dram_read_en at t+2 when the port is free and no other grant occurs.
// - Back-to-back: IDLE re-arbitrates in the cycle after the last beat. Minimum gap between issues = len+3 cycles.
// - Routing: reqN_read_data_valid = dram_read_data_valid & state==DATA & owner==N. Zero latency.
// - Stray beat: dram_read_data_valid outside DATA -> not routed, arb_error[1]<=1.
// - Capture in the same cycle as a grant of the other requester is legal and is not lost.
// - beat_cnt is 8 bits; len=255 -> 256 beats, no wrap error.
// - arb_error clears only on reset.
// CONFIGURATION
// - DRAM_ARB_TIMEOUT_EN defined:
//   - 13-bit idle counter in DATA; resets on each beat.
//   - Reaching TIMEOUT_CYCLES -> state<=IDLE, arb_error[1]<=1; remaining beats become stray.
// - DRAM_ARB_TIMEOUT_EN undefined: no counter; DATA waits indefinitely.
// TESTING
// - req0 addr=0x4_0000_0000 len=0 pulse at t=1 -> dram_read_en at t=3 with same addr/len; 1 beat -> req0_read_data_valid=1, req1 valid=0.
// - req0 and req1 pulse same cycle, len=3 each -> req0 issued first (4 beats to req0), then req1 issued; order repeats alternately on further ties.
// - dram_read_busy held 1 for 10 cycles with req1 pending -> no dram_read_en until busy drops, then issue next cycle+1.
// - req0 pulses twice while busy -> second dropped, arb_error=2'b01, only one DRAM request issued.
// - dram_read_data_valid in IDLE -> no reqN valid, arb_error[1]=1. Reset in DATA -> outputs 0, busy 0 next cycle.
// - DRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, len=1, only 1 beat -> IDLE after 16 idle cycles, arb_error[1]=1, next pending grant proceeds.

Source files
------------

// File: rtl/dram_read_arbiter.sv
`default_nettype none
// ============================================================================
// dram_read_arbiter: round-robin share of one DRAM read port by two requesters,
// one transaction in flight. Optional macro: DRAM_ARB_TIMEOUT_EN (DATA watchdog).
// Revision: 1.0
// ============================================================================
module dram_read_arbiter #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk_pixel,
  input  logic                       dram_arbiter_reset,
  input  logic [DRAM_ADDR_WIDTH-1:0] req0_read_addr,
  input  logic [7:0]                 req0_read_len,
  input  logic                       req0_read_en,
  output logic                       req0_read_busy,
  output logic                       req0_read_data_valid,
  input  logic [DRAM_ADDR_WIDTH-1:0] req1_read_addr,
  input  logic [7:0]                 req1_read_len,
  input  logic                       req1_read_en,
  output logic                       req1_read_busy,
  output logic                       req1_read_data_valid,
  output logic [DRAM_DATA_WIDTH-1:0] arb_read_data,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  output logic [7:0]                 dram_read_len,
  output logic                       dram_read_en,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  input  logic                       dram_read_data_valid,
  input  logic                       dram_read_busy,
  output logic [1:0]                 arb_error
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  // The watchdog counter is 13 bits, so the limit has to fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8192) begin : g_timeout_range_check
    $error("dram_read_arbiter: TIMEOUT_CYCLES out of range");
  end

  logic [1:0]                 state_q, state_d;
  logic                       owner_q, owner_d;
  logic                       last_grant_q, last_grant_d;
  logic [7:0]                 beat_cnt_q, beat_cnt_d;
  logic                       pending0_q, pending0_d;
  logic                       pending1_q, pending1_d;
  logic [DRAM_ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DRAM_ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic [7:0]                 len0_q, len0_d;
  logic [7:0]                 len1_q, len1_d;
  logic [1:0]                 err_q, err_d;

  logic own0, own1;
  logic accept0, accept1;
  logic overflow;
  logic stray;
  logic grant_valid;
  logic grant_sel;
  logic timeout_hit;

  assign own0 = (state_q != ST_IDLE) && !owner_q;
  assign own1 = (state_q != ST_IDLE) &&  owner_q;

  assign accept0  = req0_read_en && !pending0_q && !own0;
  assign accept1  = req1_read_en && !pending1_q && !own1;
  assign overflow = (req0_read_en && (pending0_q || own0)) ||
                    (req1_read_en && (pending1_q || own1));
  assign stray    = dram_read_data_valid && (state_q != ST_DATA);

  // On a tie, the requester that did not win last time goes first.
  assign grant_valid = (state_q == ST_IDLE) && (pending0_q || pending1_q) && !dram_read_busy;
  assign grant_sel   = (pending0_q && pending1_q) ? !last_grant_q : pending1_q;

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam logic [12:0] TIMEOUT_LIMIT = 13'(TIMEOUT_CYCLES - 1);

  logic [12:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (state_q == ST_DATA && !dram_read_data_valid) begin
      if (idle_cnt_q == TIMEOUT_LIMIT) begin
        timeout_hit = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 13'd1;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (dram_arbiter_reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pending0_d   = pending0_q;
    pending1_d   = pending1_q;
    addr0_d      = addr0_q;
    addr1_d      = addr1_q;
    len0_d       = len0_q;
    len1_d       = len1_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d      = ST_ISSUE;
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          beat_cnt_d   = grant_sel ? len1_q : len0_q;
        end
      end
      ST_ISSUE: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (dram_read_data_valid) begin
          if (beat_cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_d = ST_IDLE;
    end

    if (grant_valid && !grant_sel) pending0_d = 1'b0;
    if (grant_valid &&  grant_sel) pending1_d = 1'b0;

    // A grant only clears a set pending bit and capture only sets a clear one,
    // so a capture alongside the other requester's grant is never lost.
    if (accept0) begin
      pending0_d = 1'b1;
      addr0_d    = req0_read_addr;
      len0_d     = req0_read_len;
    end
    if (accept1) begin
      pending1_d = 1'b1;
      addr1_d    = req1_read_addr;
      len1_d     = req1_read_len;
    end

    if (overflow)              err_d[0] = 1'b1;
    if (stray || timeout_hit)  err_d[1] = 1'b1;
  end

  always_ff @(posedge clk_pixel) begin
    if (dram_arbiter_reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      pending0_q   <= 1'b0;
      pending1_q   <= 1'b0;
      addr0_q      <= '0;
      addr1_q      <= '0;
      len0_q       <= '0;
      len1_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pending0_q   <= pending0_d;
      pending1_q   <= pending1_d;
      addr0_q      <= addr0_d;
      addr1_q      <= addr1_d;
      len0_q       <= len0_d;
      len1_q       <= len1_d;
      err_q        <= err_d;
    end
  end

  assign dram_read_en   = (state_q == ST_ISSUE);
  assign dram_read_addr = dram_read_en ? (owner_q ? addr1_q : addr0_q) : '0;
  assign dram_read_len  = dram_read_en ? (owner_q ? len1_q : len0_q) : '0;

  assign arb_read_data        = dram_read_data;
  assign req0_read_data_valid = dram_read_data_valid && (state_q == ST_DATA) && !owner_q;
  assign req1_read_data_valid = dram_read_data_valid && (state_q == ST_DATA) &&  owner_q;

  assign req0_read_busy = pending0_q || own0;
  assign req1_read_busy = pending1_q || own1;
  assign arb_error      = err_q;

endmodule
`default_nettype wire
